// File: rtl/sdm2_pkg.sv
// Shared constants and types for the second-order sigma-delta bitstream transmitter.
package sdm2_pkg;

  // Default PCM sample width and integrator guard widths
  localparam int SDM2_DATA_W_DEFAULT = 16;
  localparam int SDM2_E1_GUARD       = 4;
  localparam int SDM2_E2_GUARD       = 8;
  localparam int SDM2_E1_W           = SDM2_DATA_W_DEFAULT + SDM2_E1_GUARD;
  localparam int SDM2_E2_W           = SDM2_DATA_W_DEFAULT + SDM2_E2_GUARD;

  // Shortest allowed oversampling period (dec_rate below this is clamped)
  localparam logic [15:0] SDM2_MIN_PERIOD = 16'd2;

  // Control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } sdm2_state_e;

  // Dither LFSR: 16-bit Fibonacci, taps 16,15,13,4 (bit indices 15,14,12,3)
  localparam logic [15:0] SDM2_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] SDM2_LFSR_TAPS = 16'hD008;

  // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0
  function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
    return {q[14:0], ^(q & SDM2_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sdm2_tx_lfsr16.sv
// 16-bit Fibonacci LFSR supplying the quantizer dither bit.
// Only built when SDM2_TX_DITHER_EN is defined.
`ifdef SDM2_TX_DITHER_EN
module lfsr16
  import sdm2_pkg::*;
#(
  parameter logic [15:0] SEED = SDM2_LFSR_SEED
) (
  input  logic mclk1,
  input  logic reset,
  input  logic enable,
  output logic dither_bit
);

  logic [15:0] lfsr_r;

  // Reload the seed on reset, advance one step on every enabled cycle
  always_ff @(posedge mclk1) begin
    if (reset) begin
      lfsr_r <= SEED;
    end else if (enable) begin
      lfsr_r <= lfsr16_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign dither_bit = lfsr_r[0];

endmodule
`endif

// File: rtl/sdm2_tx.sv
// Second-order CIFB sigma-delta transmitter: takes signed PCM samples with a
// ready/valid handshake, holds each for dec_rate modulator clocks and emits a
// 1-bit density-modulated stream on mdata1.
// Optional build macro SDM2_TX_DITHER_EN adds LFSR dither at the quantizer.
module sdm2_tx
  import sdm2_pkg::*;
#(
  parameter int DATA_W = SDM2_DATA_W_DEFAULT
) (
  input  logic                     mclk1,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [15:0]              dec_rate,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     mdata1,
  output logic                     underrun
);

  localparam int E1_W = DATA_W + SDM2_E1_GUARD;
  localparam int E2_W = DATA_W + SDM2_E2_GUARD;

  // Sign-extension amounts for the widened integrator sums
  localparam int X_EXT1  = E1_W + 2 - DATA_W;
  localparam int FB_EXT1 = E1_W + 1 - DATA_W;
  localparam int E1_EXT2 = E2_W + 2 - E1_W;
  localparam int FB_EXT2 = E2_W + 1 - DATA_W;

  // Saturation limits of the two integrators
  localparam logic signed [E1_W-1:0] E1_MAX = {1'b0, {(E1_W-1){1'b1}}};
  localparam logic signed [E1_W-1:0] E1_MIN = {1'b1, {(E1_W-1){1'b0}}};
  localparam logic signed [E2_W-1:0] E2_MAX = {1'b0, {(E2_W-1){1'b1}}};
  localparam logic signed [E2_W-1:0] E2_MIN = {1'b1, {(E2_W-1){1'b0}}};

  // Feedback levels: +/- half of the full-scale input range
  localparam logic signed [DATA_W:0] FB_POS = {2'b01, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W:0] FB_NEG = {2'b11, {(DATA_W-1){1'b0}}};

  // Clamp a widened e1 sum into range instead of letting it wrap
  function automatic logic signed [E1_W-1:0] sat_e1(input logic signed [E1_W+1:0] v);
    if ((v[E1_W+1:E1_W-1] == 3'b000) || (v[E1_W+1:E1_W-1] == 3'b111)) begin
      sat_e1 = v[E1_W-1:0];
    end else if (v[E1_W+1]) begin
      sat_e1 = E1_MIN;
    end else begin
      sat_e1 = E1_MAX;
    end
  endfunction

  // Clamp a widened e2 sum into range instead of letting it wrap
  function automatic logic signed [E2_W-1:0] sat_e2(input logic signed [E2_W+1:0] v);
    if ((v[E2_W+1:E2_W-1] == 3'b000) || (v[E2_W+1:E2_W-1] == 3'b111)) begin
      sat_e2 = v[E2_W-1:0];
    end else if (v[E2_W+1]) begin
      sat_e2 = E2_MIN;
    end else begin
      sat_e2 = E2_MAX;
    end
  endfunction

  sdm2_state_e              state_r;
  logic [15:0]              cnt_r;
  logic [15:0]              per_r;
  logic signed [DATA_W-1:0] x_r;
  logic signed [E1_W-1:0]   e1_r;
  logic signed [E2_W-1:0]   e2_r;
  logic                     sample_ready_r;
  logic                     mdata1_r;
  logic                     underrun_r;

  logic                     q_bit_s;
  logic signed [DATA_W:0]   fb_s;
  logic signed [E1_W+1:0]   e1_sum_s;
  logic signed [E2_W+1:0]   e2_sum_s;
  logic signed [E1_W-1:0]   e1_next_s;
  logic signed [E2_W-1:0]   e2_next_s;
  logic [15:0]              per_load_s;
  logic                     wrap_s;
  logic                     accept_s;

`ifdef SDM2_TX_DITHER_EN
  localparam logic signed [E2_W:0] DITH_ONE = {{E2_W{1'b0}}, 1'b1};
  localparam logic signed [E2_W:0] DITH_POS = DITH_ONE <<< (DATA_W - 8);
  localparam logic signed [E2_W:0] DITH_NEG = -DITH_POS;

  logic                   dither_bit_s;
  logic signed [E2_W:0]   quant_in_s;

  lfsr16 #(
    .SEED (SDM2_LFSR_SEED)
  ) u_lfsr16 (
    .mclk1      (mclk1),
    .reset      (reset),
    .enable     (state_r == ST_RUN),
    .dither_bit (dither_bit_s)
  );

  // Quantizer sees e2 nudged by +/- one dither step; integrators still use plain e2
  assign quant_in_s = $signed({e2_r[E2_W-1], e2_r}) + (dither_bit_s ? DITH_POS : DITH_NEG);
  assign q_bit_s    = ~quant_in_s[E2_W];
`else
  // Quantizer decision is the sign of e2 (zero counts as positive)
  assign q_bit_s = ~e2_r[E2_W-1];
`endif

  // Modulator datapath: feedback level and saturating integrator updates
  always_comb begin
    fb_s     = q_bit_s ? FB_POS : FB_NEG;
    e1_sum_s = $signed({{2{e1_r[E1_W-1]}}, e1_r})
             + $signed({{X_EXT1{x_r[DATA_W-1]}}, x_r})
             - $signed({{FB_EXT1{fb_s[DATA_W]}}, fb_s});
    e2_sum_s = $signed({{2{e2_r[E2_W-1]}}, e2_r})
             + $signed({{E1_EXT2{e1_r[E1_W-1]}}, e1_r})
             - $signed({{FB_EXT2{fb_s[DATA_W]}}, fb_s});
    e1_next_s = sat_e1(e1_sum_s);
    e2_next_s = sat_e2(e2_sum_s);
  end

  // Period bookkeeping: clamped reload value, end-of-period flag and handshake
  always_comb begin
    if (dec_rate < SDM2_MIN_PERIOD) begin
      per_load_s = SDM2_MIN_PERIOD;
    end else begin
      per_load_s = dec_rate;
    end
    wrap_s   = (cnt_r == (per_r - 16'd1));
    accept_s = sample_valid && sample_ready_r;
  end

  // Control FSM with the integrators, sample hold and all registered outputs
  always_ff @(posedge mclk1) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 16'd0;
      per_r          <= SDM2_MIN_PERIOD;
      x_r            <= '0;
      e1_r           <= '0;
      e2_r           <= '0;
      sample_ready_r <= 1'b0;
      mdata1_r       <= 1'b0;
      underrun_r     <= 1'b0;
    end else if (!enable) begin
      // Drop to IDLE; the idle toggle pattern restarts from 0 on entry
      state_r        <= ST_IDLE;
      cnt_r          <= 16'd0;
      e1_r           <= '0;
      e2_r           <= '0;
      sample_ready_r <= 1'b0;
      mdata1_r       <= (state_r == ST_IDLE) ? ~mdata1_r : 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r        <= ST_WAIT;
          cnt_r          <= 16'd0;
          e1_r           <= '0;
          e2_r           <= '0;
          sample_ready_r <= 1'b1;
          mdata1_r       <= ~mdata1_r;
        end
        ST_WAIT: begin
          mdata1_r <= ~mdata1_r;
          if (accept_s) begin
            state_r        <= ST_RUN;
            x_r            <= sample;
            per_r          <= per_load_s;
            cnt_r          <= 16'd0;
            sample_ready_r <= 1'b0;
          end else begin
            sample_ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          mdata1_r <= q_bit_s;
          e1_r     <= e1_next_s;
          e2_r     <= e2_next_s;
          if (wrap_s) begin
            // Period boundary: reload length, take the next sample or flag underrun
            cnt_r          <= 16'd0;
            per_r          <= per_load_s;
            sample_ready_r <= 1'b0;
            if (accept_s) begin
              x_r <= sample;
            end else begin
              underrun_r <= 1'b1;
            end
          end else begin
            cnt_r          <= cnt_r + 16'd1;
            sample_ready_r <= ((cnt_r + 16'd1) == (per_r - 16'd1));
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          cnt_r          <= 16'd0;
          e1_r           <= '0;
          e2_r           <= '0;
          sample_ready_r <= 1'b0;
          mdata1_r       <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready = sample_ready_r;
  assign mdata1       = mdata1_r;
  assign underrun     = underrun_r;

endmodule
